// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, the master FSM state type and the request
// legality helper used by the two-requester AHB master arbiter.
package ahb_pkg;

  // htrans encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Only single transfers are issued
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Data access, privileged, non-bufferable, non-cacheable
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } ahb_state_e;

  // A request is legal when its size fits the data bus and the address
  // is naturally aligned to that size. Only the low three address bits
  // matter because sizes above 3 are already rejected for 32/64-bit buses.
  function automatic logic req_legal(input logic [2:0] size,
                                     input logic [2:0] addr_lo,
                                     input logic [2:0] max_size);
    logic [3:0] span;
    logic [2:0] mask;
    span = 4'd1 << size;
    mask = 3'(span - 4'd1);
    if (size > max_size) return 1'b0;
    return (addr_lo & mask) == 3'd0;
  endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// AHB-lite master-side bus bundle. The master modport drives the address
// and write-data phase signals; the slave modport returns hready/hrdata/hresp.
interface ahb_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hready, hrdata, hresp
  );

endinterface

// File: rtl/ahb_rr_arbiter.sv
// Two-way round-robin grant. On a tie the requester that was not granted
// most recently wins; after reset requester 0 wins the first tie.
module ahb_rr_arbiter (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = requester 1 was the most recent grant
  logic last_q;

  // Grant selection from the live request vector and the last winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who won whenever a grant is actually consumed
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-requester AHB-lite master. Requests are arbitrated round-robin,
// checked for legality, and turned into single NONSEQ transfers.
//
// Requester handshake: a request transfers on a rising edge where
// req_valid[i] and req_ready[i] are both high. req_ready is only offered in
// IDLE, to one requester at a time, and valid need not be held; a request
// dropped before that edge is simply never seen. Each accepted request gets
// exactly one single-cycle rsp_valid[i] pulse carrying rsp_rdata/rsp_err.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]              req_write,
  input  logic [5:0]              req_size,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  ahb_master_arbiter_if.master    ahb,
  output ahb_state_e              dbg_state
);

  localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  ahb_state_e state_q, state_d;

  logic [1:0]            gnt;
  logic                  gsel;
  logic                  grant_en;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic [2:0]            sel_size;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_legal;

  logic                  gidx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  ahb_rr_arbiter u_rr (
    .hclk    (hclk),
    .hresetn (hresetn),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  // Ready is withheld outside IDLE and while reset is asserted
  assign grant_en  = (state_q == ST_IDLE) && hresetn;
  assign req_ready = gnt & {2{grant_en}};
  assign accept    = |(req_ready & req_valid);
  assign gsel      = gnt[1];

  assign sel_addr  = gsel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_write = gsel ? req_write[1] : req_write[0];
  assign sel_size  = gsel ? req_size[5:3] : req_size[2:0];
  assign sel_wdata = gsel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign sel_legal = req_legal(sel_size, sel_addr[2:0], MAX_SIZE);

  assign dbg_state = state_q;

  // FSM state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: illegal acceptances stay in IDLE, wait states hold the phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && sel_legal) state_d = ST_ADDR;
      ST_ADDR: if (ahb.hready) state_d = ST_DATA;
      ST_DATA: if (ahb.hready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the state and the latched request
  always_comb begin
    ahb.hsel   = 1'b0;
    ahb.haddr  = '0;
    ahb.htrans = HTRANS_IDLE;
    ahb.hwrite = 1'b0;
    ahb.hsize  = 3'd0;
    ahb.hburst = HBURST_SINGLE;
    ahb.hprot  = 4'd0;
    ahb.hwdata = '0;
    case (state_q)
      ST_ADDR: begin
        ahb.hsel   = 1'b1;
        ahb.haddr  = addr_q;
        ahb.htrans = HTRANS_NONSEQ;
        ahb.hwrite = write_q;
        ahb.hsize  = size_q;
        ahb.hprot  = HPROT_DEFAULT;
      end
      ST_DATA: begin
        ahb.hwdata = write_q ? wdata_q : '0;
      end
      default: ;
    endcase
  end

  // Request latch and registered response; rsp_valid is a one-cycle pulse
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      gidx_q    <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      wdata_q   <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      if (accept) begin
        gidx_q  <= gsel;
        addr_q  <= sel_addr;
        write_q <= sel_write;
        size_q  <= sel_size;
        wdata_q <= sel_wdata;
        if (!sel_legal) begin
          rsp_valid <= gnt;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      if (state_q == ST_DATA && ahb.hready) begin
        rsp_valid <= gidx_q ? 2'b10 : 2'b01;
        rsp_rdata <= ahb.hrdata;
        rsp_err   <= ahb.hresp;
      end
    end
  end

endmodule
